fb_port_arbiter: RTL and testbench
==================================

// Module: fb_port_arbiter
// PURPOSE
// - Shares one single-port synchronous frame-buffer RAM (QVGA 320x240, RGB565) between the
//   camera pixel writer and the 640x480 VGA scan-out path.
// - VGA reads get even-x cycles of the active area (2x upscale); queued camera writes drain on
//   all other cycles. Includes a tear-free freeze controller.
// - Sits between the VGA sync generator (h/v/DE/x/y) and the VGA RGB output stage.
// PARAMETERS
// - IMG_W      320  frame-buffer width in pixels
// - IMG_H      240  frame-buffer height in pixels
// - ADDR_W     17   RAM address width (IMG_W*IMG_H = 76800 words)
// - DATA_W     16   pixel width (RGB565)
// - FIFO_DEPTH 8    camera write queue depth (power of 2)
// PORTS
// - clk         in   1       system/pixel clock (one clock domain)
// - reset_n     in   1       asynchronous, active-low reset
// - vga_hs_in   in   1       h_sync from sync generator (active-low)
// - vga_vs_in   in   1       v_sync from sync generator (active-low)
// - vga_de      in   1       display enable
// - vga_x       in   10      current pixel column, 0..799
// - vga_y       in   10      current pixel line, 0..524
// - cam_valid   in   1       camera write request
// - cam_ready   out  1       write accepted when cam_valid && cam_ready
// - cam_addr    in   ADDR_W  camera write address
// - cam_data    in   DATA_W  camera write pixel
// - cam_vs      in   1       1-cycle pulse at camera frame start
// - freeze_req  in   1       level: 1 = hold the displayed image
// - frozen      out  1       1 while in the FROZEN state
// - cam_ovf     out  1       sticky: cam_valid seen while cam_ready=0
// - ram_en, ram_we  out 1    RAM strobes
// - ram_addr    out  ADDR_W  RAM address
// - ram_wdata   out  DATA_W  RAM write data
// - ram_rdata   in   DATA_W  RAM read data, valid 1 cycle after ram_en && !ram_we
// - pix_hs, pix_vs  out 1    sync signals delayed 2 cycles
// - pix_de      out  1       vga_de delayed 2 cycles
// - pix_data    out  DATA_W  pixel aligned with pix_de; 0 when pix_de=0
// BEHAVIOUR
// - Reset: FIFO empty, mode LIVE, cam_ovf=0, frozen=0, ram_en/ram_we=0, pix_de=0,
//   pix_data=0, pix_hs=pix_vs=1. cam_ready=1 after release. Mid-op reset flushes queued writes.
// - Read slot: rd = vga_de && !vga_x[0]. Issue ram_en=1, ram_we=0,
//   ram_addr = (vga_y>>1)*IMG_W + (vga_x>>1), computed as shift-add, ADDR_W bits.
// - Read data capture: cycle N+1 captures ram_rdata into a hold reg; pix_data is valid at N+2
//   and held at N+3 for the odd column. Pixel latency is 2 cycles, matching pix_hs/pix_vs/pix_de.
// - Write slot: any cycle with !rd and FIFO non-empty pops the head and issues ram_en=1,
//   ram_we=1 with the popped addr/data. Reads always win; no write while rd=1.
// - Idle: !rd and FIFO empty -> ram_en=0.
// - FIFO: cam_ready = (count < FIFO_DEPTH), from registered count only. Push and pop may occur
//   in the same cycle (count unchanged). When full and popping, ready is still 0 that cycle.
// - cam_ovf: set on cam_valid && !cam_ready; cleared only by reset.
// - Freeze FSM, 2-bit: LIVE -> FRZ_PEND when freeze_req=1.
//   FRZ_PEND -> FROZEN on cam_vs. FRZ_PEND -> LIVE if freeze_req drops first.
//   FROZEN -> LIVE_PEND when freeze_req=0. LIVE_PEND -> LIVE on cam_vs.
//   LIVE_PEND -> FROZEN if freeze_req rises again.
// - In FROZEN and LIVE_PEND, accepted camera writes are discarded: not pushed, cam_ready=1.
//   Entries already queued still drain.
// - cam_vs in the same cycle as a mode transition: the new mode applies from the next cycle.
// - frozen = (state == FROZEN).
// TESTING
// - Reset, then one active line at y=0: RAM reads at x=0,2,..,638 with addr 0..319.
//   pix_data shows each word twice, 2 cycles after x. No writes during the line.
// - y=479, x=638: ram_addr = 239*320+319 = 76799. Blanking (x>=640) -> no reads issued.
// - 8 back-to-back cam writes during an active line: all accepted, a 9th is held off
//   (cam_ready=0). Writes are drained on odd-x cycles in FIFO order; data is verified by readback.
// - Hold cam_valid=1 while the FIFO is full -> cam_ovf=1 and stays 1 until reset_n=0.
// - freeze_req=1 mid-frame: writes continue until cam_vs, then frozen=1 and RAM contents are
//   unchanged for a full frame. freeze_req=0: writes resume only after the next cam_vs.
// - Assert reset_n=0 with 5 entries queued: no RAM write after reset, cam_ready=1, state LIVE.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: VGA scan-out reads on even active columns, queued camera
// writes drain on every other cycle, with a freeze controller synchronised to camera frames.
module fb_port_arbiter #(
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vga_hs_in,
  input  logic              vga_vs_in,
  input  logic              vga_de,
  input  logic [9:0]        vga_x,
  input  logic [9:0]        vga_y,
  input  logic              cam_valid,
  output logic              cam_ready,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_data,
  input  logic              cam_vs,
  input  logic              freeze_req,
  output logic              frozen,
  output logic              cam_ovf,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              pix_hs,
  output logic              pix_vs,
  output logic              pix_de,
  output logic [DATA_W-1:0] pix_data,
  output logic [1:0]        dbg_state
);

  // Camera handshake: a word transfers on any cycle where cam_valid && cam_ready;
  // cam_valid may be raised or dropped freely, and cam_ready never depends on cam_valid.

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int unused_fb_words = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    LIVE      = 2'd0,
    FRZ_PEND  = 2'd1,
    FROZEN    = 2'd2,
    LIVE_PEND = 2'd3
  } frz_state_t;

  frz_state_t state;

  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;

  logic              rd, push, pop, discard;
  logic [ADDR_W-1:0] x_half, y_half, rd_addr;
  logic [1:0]        hs_d, vs_d, de_d;
  logic              rd_d1;
  logic [DATA_W-1:0] hold;
  logic              unused_bits;

  assign unused_bits = vga_y[0];

  // Row stride of 320 = 256 + 64, so the scan address needs no multiplier.
  assign x_half  = ADDR_W'(vga_x[9:1]);
  assign y_half  = ADDR_W'(vga_y[9:1]);
  assign rd_addr = (y_half << 8) + (y_half << 6) + x_half;

  assign rd        = vga_de && !vga_x[0];
  assign discard   = (state == FROZEN) || (state == LIVE_PEND);
  assign cam_ready = discard || (count < (PTR_W+1)'(FIFO_DEPTH));
  assign push      = cam_valid && cam_ready && !discard;
  assign pop       = !rd && (count != '0);

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = rd_addr;
    ram_wdata = q_data[rd_ptr];
    if (rd) begin
      ram_en = 1'b1;
    end else if (pop) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = q_addr[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= cam_addr;
      q_data[wr_ptr] <= cam_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      cam_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (cam_valid && !cam_ready) cam_ovf <= 1'b1;
    end
  end

  // Two-stage sync pipe; the hold register keeps the even-column word for the odd column too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_d  <= 2'b11;
      vs_d  <= 2'b11;
      de_d  <= 2'b00;
      rd_d1 <= 1'b0;
      hold  <= '0;
    end else begin
      hs_d  <= {hs_d[0], vga_hs_in};
      vs_d  <= {vs_d[0], vga_vs_in};
      de_d  <= {de_d[0], vga_de};
      rd_d1 <= rd;
      if (rd_d1) hold <= ram_rdata;
    end
  end

  assign pix_hs   = hs_d[1];
  assign pix_vs   = vs_d[1];
  assign pix_de   = de_d[1];
  assign pix_data = pix_de ? hold : '0;

  // Mode changes only take effect on a camera frame boundary, so a frame is never torn.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= LIVE;
      frozen <= 1'b0;
    end else begin
      case (state)
        LIVE: begin
          if (freeze_req) state <= FRZ_PEND;
        end
        FRZ_PEND: begin
          if (!freeze_req) begin
            state <= LIVE;
          end else if (cam_vs) begin
            state  <= FROZEN;
            frozen <= 1'b1;
          end
        end
        FROZEN: begin
          if (!freeze_req) begin
            state  <= LIVE_PEND;
            frozen <= 1'b0;
          end
        end
        LIVE_PEND: begin
          if (freeze_req) begin
            state  <= FROZEN;
            frozen <= 1'b1;
          end else if (cam_vs) begin
            state <= LIVE;
          end
        end
        default: begin
          state  <= LIVE;
          frozen <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed phases plus random traffic, checked cycle by cycle
// against a queue/array model of the RAM, camera FIFO, freeze mode and output pipeline.
module tb_fb_port_arbiter;

  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int PIX    = IMG_W * IMG_H;

  logic              clk;
  logic              reset_n;
  logic              vga_hs_in, vga_vs_in, vga_de;
  logic [9:0]        vga_x, vga_y;
  logic              cam_valid, cam_ready;
  logic [ADDR_W-1:0] cam_addr;
  logic [DATA_W-1:0] cam_data;
  logic              cam_vs, freeze_req, frozen, cam_ovf;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              pix_hs, pix_vs, pix_de;
  logic [DATA_W-1:0] pix_data;
  logic [1:0]        dbg_state;

  fb_port_arbiter #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .vga_hs_in(vga_hs_in), .vga_vs_in(vga_vs_in), .vga_de(vga_de),
    .vga_x(vga_x), .vga_y(vga_y),
    .cam_valid(cam_valid), .cam_ready(cam_ready), .cam_addr(cam_addr), .cam_data(cam_data),
    .cam_vs(cam_vs), .freeze_req(freeze_req), .frozen(frozen), .cam_ovf(cam_ovf),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .pix_hs(pix_hs), .pix_vs(pix_vs), .pix_de(pix_de), .pix_data(pix_data),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int i);
    return 16'((i * 40503) ^ (i >> 3));
  endfunction

  // single-port synchronous RAM seen by the DUT
  logic [15:0] ram [PIX];
  bit          ram_init = 1'b0;
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < PIX; i++) ram[i] <= pat(i);
      ram_init <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) begin
        ram[ram_addr] <= ram_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        ram_rdata <= ram[ram_addr];
      end
    end
  end

  // reference model and scoreboard
  logic [15:0] ref_mem [PIX];
  logic [16:0] mq_a [$];
  logic [15:0] mq_d [$];
  logic [18:0] exp_q [$];
  bit          m_frozen, m_pend, m_ovf;
  logic [15:0] last_rd;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq_a.delete();
    mq_d.delete();
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b1, 1'b0, 16'h0});
    exp_q.push_back({1'b1, 1'b1, 1'b0, 16'h0});
    m_frozen = 1'b0;
    m_pend   = 1'b0;
    m_ovf    = 1'b0;
    last_rd  = '0;
  endtask

  // driver: one clock cycle of stimulus, checked against the model
  task automatic cyc(input bit rst, input bit de, input int x, input int y, input bit cv,
                     input int ca, input logic [15:0] cd, input bit cvs, input bit frq);
    logic        hs, vs;
    logic [15:0] px;
    logic [18:0] e;
    bit          rd, ready;
    int          ea;
    @(negedge clk);
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    reset_n = rst;  vga_de = de;  vga_x = 10'(x);  vga_y = 10'(y);
    vga_hs_in = hs; vga_vs_in = vs;
    cam_valid = cv; cam_addr = 17'(ca); cam_data = cd; cam_vs = cvs; freeze_req = frq;
    #1;
    if (!rst) begin
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ready", cam_ready, 1);
      chk("rst_ovf", cam_ovf, 0);
      chk("rst_frozen", frozen, 0);
      chk("rst_state", dbg_state, 0);
      chk("rst_pix_hs", pix_hs, 1);
      chk("rst_pix_vs", pix_vs, 1);
      chk("rst_pix_de", pix_de, 0);
      chk("rst_pix_data", pix_data, 0);
      model_reset();
      return;
    end
    rd    = de && (x % 2 == 0);
    ready = m_frozen || (mq_a.size() < DEPTH);
    chk("cam_ready", cam_ready, ready);
    chk("cam_ovf", cam_ovf, m_ovf);
    chk("frozen", frozen, m_frozen && !m_pend);
    if (rd) begin
      ea = (y / 2) * IMG_W + x / 2;
      chk("rd_en", ram_en, 1);
      chk("rd_we", ram_we, 0);
      chk("rd_addr", ram_addr, ea);
      last_rd = ref_mem[ea];
    end else if (mq_a.size() > 0) begin
      chk("wr_en", ram_en, 1);
      chk("wr_we", ram_we, 1);
      chk("wr_addr", ram_addr, mq_a[0]);
      chk("wr_data", ram_wdata, mq_d[0]);
      ref_mem[mq_a[0]] = mq_d[0];
      void'(mq_a.pop_front());
      void'(mq_d.pop_front());
    end else begin
      chk("idle_en", ram_en, 0);
    end
    if (cv && ready && !m_frozen) begin
      mq_a.push_back(17'(ca));
      mq_d.push_back(cd);
    end
    if (cv && !ready) m_ovf = 1'b1;
    e = exp_q.pop_front();
    chk("pix_hs", pix_hs, e[18]);
    chk("pix_vs", pix_vs, e[17]);
    chk("pix_de", pix_de, e[16]);
    chk("pix_data", pix_data, e[15:0]);
    px = de ? last_rd : 16'h0;
    exp_q.push_back({hs, vs, de, px});
    if (frq == m_frozen) begin
      m_pend = 1'b0;
    end else if (m_pend && cvs) begin
      m_frozen = frq;
      m_pend   = 1'b0;
    end else begin
      m_pend = 1'b1;
    end
  endtask

  // stimulus
  initial begin
    int w0, px, py;
    bit frq;
    for (int i = 0; i < PIX; i++) ref_mem[i] = pat(i);
    reset_n = 1'b0; vga_de = 1'b0; vga_x = '0; vga_y = '0; vga_hs_in = 1'b1; vga_vs_in = 1'b1;
    cam_valid = 1'b0; cam_addr = '0; cam_data = '0; cam_vs = 1'b0; freeze_req = 1'b0;
    model_reset();
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // one active line at y=0 plus blanking, no camera traffic
    w0 = wr_cnt;
    for (int x = 0; x < 680; x++) cyc(1, x < 640, x, 0, 0, 0, 0, 0, 0);
    chk("line0_no_writes", wr_cnt - w0, 0);

    // last line corner and blanking
    for (int x = 600; x < 700; x++) begin
      cyc(1, x < 640, x, 479, 0, 0, 0, 0, 0);
      if (x == 638) chk("addr_corner", ram_addr, 76799);
      if (x == 640) chk("blank_no_read", ram_en, 0);
    end

    // fill the FIFO while every cycle is a read slot, then let it drain
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, 2 * i, 20, 1, 6400 + 5 * i, 16'($urandom), 0, 0);
      if (i == 7) chk("eighth_accepted", cam_ready, 1);
      if (i == 8) chk("ninth_held_off", cam_ready, 0);
    end
    chk("ovf_set", cam_ovf, 1);
    for (int x = 24; x < 680; x++) cyc(1, x < 640, x, 20, 0, 0, 0, 0, 0);
    for (int y = 40; y < 42; y++)
      for (int x = 0; x < 660; x++) cyc(1, x < 640, x, y, 0, 0, 0, 0, 0);
    chk("ovf_sticky", cam_ovf, 1);

    // random traffic with freeze requests and camera frame pulses
    px = 0; py = $urandom_range(0, 479); frq = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) frq = !frq;
      cyc(1, px < 640, px, py, 1'($urandom_range(0, 1)), $urandom_range(0, PIX - 1),
          16'($urandom), $urandom_range(0, 9) == 0, frq);
      px++;
      if (px == 800) begin px = 0; py = $urandom_range(0, 479); end
    end

    // directed freeze sequence from a known LIVE state
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("live_again", frozen, 0);
    w0 = wr_cnt;
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 1, $urandom_range(0, PIX - 1), 16'($urandom), 0, 1);
    chk("pend_writes_continue", wr_cnt - w0 > 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("frozen_set", frozen, 1);
    w0 = wr_cnt;
    for (int x = 0; x < 200; x++)
      cyc(1, x < 160, x, 300, 1, $urandom_range(0, PIX - 1), 16'($urandom), 0, 1);
    chk("frozen_no_writes", wr_cnt - w0, 0);
    w0 = wr_cnt;
    for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0, 1, $urandom_range(0, PIX - 1), 16'($urandom), 0, 0);
    chk("live_pend_no_writes", wr_cnt - w0, 0);
    chk("live_pend_not_frozen", frozen, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    w0 = wr_cnt;
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 1, $urandom_range(0, PIX - 1), 16'($urandom), 0, 0);
    chk("writes_resume", wr_cnt - w0 > 0, 1);
    repeat (4) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset with five writes queued
    for (int i = 0; i < 5; i++) cyc(1, 1, 2 * i, 100, 1, 100 + i, 16'($urandom), 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    w0 = wr_cnt;
    repeat (20) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_no_writes", wr_cnt - w0, 0);
    chk("flush_ready", cam_ready, 1);
    chk("flush_state_live", dbg_state, 0);
    chk("flush_ovf_clear", cam_ovf, 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
